// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the write-back port arbiter:
// data-mux select encodings, source count and FSM state type.
package wb_port_arbiter_pkg;

    localparam int NUM_SRC = 4;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_IMM = 2'd2;
    localparam logic [1:0] SEL_PC  = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        BEAT2 = 1'b1
    } fsm_t;

    function automatic logic [1:0] next_ptr(input logic [1:0] sel);
        return sel + 2'd1;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back request/grant bundle between the four write-back sources
// (master side) and the register-file port arbiter (slave side).
interface wb_port_arbiter_if #(
    parameter int ADDR_W = 4
);
    import wb_port_arbiter_pkg::*;

    logic [NUM_SRC-1:0]        req;
    logic [NUM_SRC-1:0]        req_burst;
    logic [NUM_SRC*ADDR_W-1:0] req_addr;
    logic [NUM_SRC-1:0]        gnt;
    logic [NUM_SRC-1:0]        stall;
    logic [1:0]                mux_sel;
    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_waddr;
    logic                      busy;
    logic                      burst_abort;

    modport master (
        output req, req_burst, req_addr,
        input  gnt, stall, mux_sel, rf_we, rf_waddr, busy, burst_abort
    );

    modport slave (
        input  req, req_burst, req_addr,
        output gnt, stall, mux_sel, rf_we, rf_waddr, busy, burst_abort
    );

endinterface

// File: rtl/wb_port_arbiter_rr_pick4.sv
// Rotating priority encoder: returns the first asserted request found
// scanning from ptr upward, wrapping modulo 4.
module wb_port_arbiter_rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] pos;

    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        pos   = ptr;
        for (int k = 0; k < 4; k++) begin
            pos = ptr + 2'(k);
            if (!valid && req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a
// two-beat burst mode that writes Rd then Rd+1 back to back.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    fsm_t               fsm, fsm_next;
    logic [1:0]         rr_ptr, rr_next;
    logic [1:0]         owner, owner_next;
    logic [ADDR_W-1:0]  base_addr, base_next;
    logic [1:0]         last_sel;
    logic               burst_abort, abort_next;

    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic [ADDR_W-1:0]  src_addr [NUM_SRC];

    logic [NUM_SRC-1:0] gnt;
    logic [1:0]         mux_sel;
    logic               rf_we;
    logic [ADDR_W-1:0]  rf_waddr;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_addr
        assign src_addr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    end

    wb_port_arbiter_rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            rr_ptr      <= 2'd0;
            owner       <= 2'd0;
            base_addr   <= '0;
            last_sel    <= SEL_ALU;
            burst_abort <= 1'b0;
        end else begin
            fsm         <= fsm_next;
            rr_ptr      <= rr_next;
            owner       <= owner_next;
            base_addr   <= base_next;
            burst_abort <= abort_next;
            if (rf_we) begin
                last_sel <= mux_sel;
            end
        end
    end

    // Grants are combinational so a winning source writes in the same cycle it asks.
    always_comb begin
        fsm_next   = fsm;
        rr_next    = rr_ptr;
        owner_next = owner;
        base_next  = base_addr;
        abort_next = 1'b0;
        gnt        = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        mux_sel    = last_sel;

        case (fsm)
            IDLE: begin
                if (pick_valid) begin
                    gnt[pick_idx] = 1'b1;
                    rf_we         = 1'b1;
                    mux_sel       = pick_idx;
                    rf_waddr      = src_addr[pick_idx];
                    if (bus.req_burst[pick_idx]) begin
                        fsm_next   = BEAT2;
                        owner_next = pick_idx;
                        base_next  = src_addr[pick_idx];
                    end else begin
                        rr_next = next_ptr(pick_idx);
                    end
                end
            end
            BEAT2: begin
                fsm_next = IDLE;
                rr_next  = next_ptr(owner);
                if (bus.req[owner]) begin
                    gnt[owner] = 1'b1;
                    rf_we      = 1'b1;
                    mux_sel    = owner;
                    rf_waddr   = base_addr + ADDR_W'(1);
                end else begin
                    abort_next = 1'b1;
                end
            end
            default: fsm_next = IDLE;
        endcase

        if (rst) begin
            gnt      = '0;
            rf_we    = 1'b0;
            rf_waddr = '0;
            mux_sel  = SEL_ALU;
        end
    end

    assign bus.gnt         = gnt;
    assign bus.stall       = rst ? '0 : (bus.req & ~gnt);
    assign bus.mux_sel     = mux_sel;
    assign bus.rf_we       = rf_we;
    assign bus.rf_waddr    = rf_waddr;
    assign bus.busy        = (fsm == BEAT2) && !rst;
    assign bus.burst_abort = burst_abort;

endmodule
